prog_loader: RTL and testbench

- Front-end loader that sits directly upstream of the control unit. It drives that unit's instruction-load enable and instruction-input byte.
- Accepts program bytes from a host over a valid/ready handshake and buffers them in a small FIFO. Writes one byte per cycle into program memory as a single-cycle load pulse.
- Signals run-ready once the program is complete, either on the last-flagged byte or on reaching PROG_LEN.

---
 rtl/prog_loader.sv | 133 +++++++++++++
 tb/tb_prog_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: buffers host instruction bytes in a small FIFO and streams
// them into control-unit program memory as single-cycle load strobes.
module prog_loader #(
  parameter int DEPTH    = 4,
  parameter int PROG_LEN = 16,
  parameter int INSTR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               in_last,
  output logic               in_ready,
  input  logic               hold,
  output logic               load,
  output logic [INSTR_W-1:0] instr_i,
  output logic               run,
  output logic               busy,
  output logic [4:0]         count,
  output logic               ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C    = OCC_W'(DEPTH);
  localparam logic [4:0]       PROG_LEN_C = 5'(PROG_LEN);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t state, state_nxt;

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [OCC_W-1:0]   occ;
  logic [4:0]         acc, acc_inc;
  logic               last_seen;
  logic               full, empty;
  logic               push, pop;
  logic               session_clr, last_hit, ovf_hit;

  assign full    = (occ == DEPTH_C);
  assign empty   = (occ == '0);
  assign acc_inc = acc + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FLUSH only exits once the last popped byte has actually been strobed out.
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    busy        = 1'b0;
    run         = 1'b0;
    session_clr = 1'b0;
    last_hit    = 1'b0;
    ovf_hit     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt   = LOAD;
          session_clr = 1'b1;
        end
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = !full && !last_seen && (acc < PROG_LEN_C);
        push     = in_valid && in_ready;
        pop      = !empty && !hold;
        last_hit = push && (in_last || (acc_inc == PROG_LEN_C));
        ovf_hit  = push && !in_last && (acc_inc == PROG_LEN_C);
        if (last_hit) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        pop  = !empty && !hold;
        if (empty && !load) state_nxt = DONE;
      end
      DONE: begin
        run = 1'b1;
        if (start) begin
          state_nxt   = LOAD;
          session_clr = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // instr_i keeps its last value between pops; only load drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load      <= 1'b0;
      instr_i   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      last_seen <= 1'b0;
    end else begin
      load <= pop;
      if (pop) begin
        instr_i <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (push && !pop)      occ <= occ + OCC_W'(1);
      else if (!push && pop) occ <= occ - OCC_W'(1);
      if (session_clr) begin
        acc       <= '0;
        count     <= '0;
        ovf       <= 1'b0;
        last_seen <= 1'b0;
      end else begin
        if (push)     acc       <= acc_inc;
        if (pop)      count     <= count + 5'd1;
        if (last_hit) last_seen <= 1'b1;
        if (ovf_hit)  ovf       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: accepted bytes are queued as expected
// instructions and matched against every load strobe in arrival order.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_last, hold;
  logic [7:0] in_data;
  logic       in_ready, load, run, busy, ovf;
  logic [7:0] instr_i;
  logic [4:0] count;

  prog_loader #(.DEPTH(4), .PROG_LEN(16), .INSTR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .hold(hold), .load(load), .instr_i(instr_i), .run(run),
    .busy(busy), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         total = 0;
  int         bad = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int         load_cnt, first_load_cyc, last_load_cyc, first_acc_cyc, sess_acc;
  int         load_base;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h want=0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Every load strobe must match the oldest accepted byte still outstanding.
  task automatic monitorLoads();
    forever begin
      @(negedge clk);
      if (load) begin
        load_cnt++;
        if (first_load_cyc < 0) first_load_cyc = cyc;
        last_load_cyc = cyc;
        if (sb.size() == 0) checkOutput("load_without_byte", 32'(load), 32'd0);
        else begin
          exp_b = sb.pop_front();
          checkOutput("instr_i", 32'(instr_i), 32'(exp_b));
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic l);
    int waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
    else begin
      sb.push_back(d);
      if (sess_acc == 0) first_acc_cyc = cyc;
      sess_acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic newSession();
    load_cnt       = 0;
    first_load_cyc = -1;
    sess_acc       = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitRun();
    int n = 0;
    while (!run && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("run_high", 32'(run), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; hold = 1'b0; in_data = '0;
    load_cnt = 0; first_load_cyc = -1; last_load_cyc = 0; first_acc_cyc = 0; sess_acc = 0;
    fork
      monitorLoads();
    join_none
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_load", 32'(load), 32'd0);
    checkOutput("rst_run", 32'(run), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_instr_i", 32'(instr_i), 32'd0);
    @(negedge clk);

    $display("[TB] three-byte program");
    newSession();
    applyStimulus(8'hA1, 1'b0);
    applyStimulus(8'hB2, 1'b0);
    applyStimulus(8'hC3, 1'b1);
    waitRun();
    checkOutput("t1_latency", 32'(first_load_cyc - first_acc_cyc), 32'd2);
    checkOutput("t1_back_to_back", 32'(last_load_cyc - first_load_cyc), 32'd2);
    checkOutput("t1_loads", 32'(load_cnt), 32'd3);
    checkOutput("t1_count", 32'(count), 32'd3);
    checkOutput("t1_ovf", 32'(ovf), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] full-length program without last");
    newSession();
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b0);
    checkOutput("t2_ready_drop", 32'(in_ready), 32'd0);
    waitRun();
    checkOutput("t2_loads", 32'(load_cnt), 32'd16);
    checkOutput("t2_count", 32'(count), 32'd16);
    checkOutput("t2_ovf", 32'(ovf), 32'd1);

    $display("[TB] full-length program with last on final byte");
    newSession();
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), (i == 15) ? 1'b1 : 1'b0);
    waitRun();
    checkOutput("t2b_loads", 32'(load_cnt), 32'd16);
    checkOutput("t2b_count", 32'(count), 32'd16);
    checkOutput("t2b_ovf", 32'(ovf), 32'd0);

    $display("[TB] hold with FIFO filling");
    hold = 1'b1;
    newSession();
    for (int i = 0; i < 4; i++) applyStimulus(8'h60 + 8'(i), 1'b0);
    checkOutput("t3_full_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t3_no_loads", 32'(load_cnt), 32'd0);
    checkOutput("t3_count_held", 32'(count), 32'd0);
    hold = 1'b0;
    applyStimulus(8'h64, 1'b0);
    applyStimulus(8'h65, 1'b1);
    waitRun();
    checkOutput("t3_loads", 32'(load_cnt), 32'd6);
    checkOutput("t3_count", 32'(count), 32'd6);
    checkOutput("t3_ovf", 32'(ovf), 32'd0);

    $display("[TB] asynchronous reset mid-load");
    newSession();
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b0);
    checkOutput("t4_pre_count", 32'(count), 32'd2);
    checkOutput("t4_pre_load", 32'(load), 32'd1);
    #2 rst = 1'b1;
    #1;
    load_base = load_cnt;
    checkOutput("t4_load", 32'(load), 32'd0);
    checkOutput("t4_run", 32'(run), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_count", 32'(count), 32'd0);
    checkOutput("t4_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t4_no_more_loads", 32'(load_cnt - load_base), 32'd0);
    checkOutput("t4_post_load", 32'(load), 32'd0);
    checkOutput("t4_post_count", 32'(count), 32'd0);
    sb.delete();

    $display("[TB] start ignored during load");
    newSession();
    applyStimulus(8'h40, 1'b0);
    applyStimulus(8'h41, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t6_count_kept", 32'(count), 32'd2);
    checkOutput("t6_busy", 32'(busy), 32'd1);
    applyStimulus(8'h42, 1'b0);
    applyStimulus(8'h43, 1'b1);
    waitRun();
    checkOutput("t6_loads", 32'(load_cnt), 32'd4);
    checkOutput("t6_count", 32'(count), 32'd4);
    checkOutput("t6_ovf", 32'(ovf), 32'd0);

    $display("[TB] restart from done");
    newSession();
    checkOutput("t5_run_drop", 32'(run), 32'd0);
    checkOutput("t5_count_clr", 32'(count), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd1);
    applyStimulus(8'h5E, 1'b1);
    waitRun();
    checkOutput("t5_loads", 32'(load_cnt), 32'd1);
    checkOutput("t5_count", 32'(count), 32'd1);
    checkOutput("t5_instr_i", 32'(instr_i), 32'h5E);
    checkOutput("t5_ovf", 32'(ovf), 32'd0);
    checkOutput("t5_sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
